rf_ctx_seq: RTL



---
 rtl/rf_ctx_seq.sv | 77 +++++++
 1 files changed

// File: rtl/rf_ctx_seq.sv
// rf_ctx_seq: context save/restore sequencer between the CPU datapath and an NREG x W register file
//    cpu_*                        CPU read-1 select and write port, passed through when not busy
//    rf_*                         register file read-1 select/data and write port
//    save_start / restore_start   sequence requests, sampled in IDLE
//    save_data/valid/ready        register stream out (SAVE)
//    restore_data/valid/ready     register stream in (RESTORE)
//    busy, cpu_stall, done, err   status: sequence running, CPU blocked, completion pulse, illegal command
module rf_ctx_seq #(
   parameter int NREG = 8,
   parameter int W    = 16,
   parameter int SELW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            save_start,
   input  logic            restore_start,
   input  logic [SELW-1:0] cpu_read1regsel,
   input  logic            cpu_write,
   input  logic [SELW-1:0] cpu_writeregsel,
   input  logic [W-1:0]    cpu_writedata,
   input  logic [W-1:0]    rf_read1data,
   output logic [SELW-1:0] rf_read1regsel,
   output logic            rf_write,
   output logic [SELW-1:0] rf_writeregsel,
   output logic [W-1:0]    rf_writedata,
   output logic [W-1:0]    save_data,
   output logic            save_valid,
   input  logic            save_ready,
   input  logic [W-1:0]    restore_data,
   input  logic            restore_valid,
   output logic            restore_ready,
   output logic            busy,
   output logic            cpu_stall,
   output logic            done,
   output logic            err
);
   typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;
   state_t          state;
   logic [SELW-1:0] idx;
   logic            last, save_mode, rest_mode;
   assign last      = idx == SELW'(NREG - 1);
   assign save_mode = !rst && state == SAVE;
   assign rest_mode = !rst && state == RESTORE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         case (state)
            IDLE: if (save_start ^ restore_start) begin
               state <= save_start ? SAVE : RESTORE;
               idx   <= '0;
            end
            SAVE: if (save_ready) begin
               state <= last ? DONE : SAVE;
               idx   <= last ? idx : idx + 1'b1;
            end
            RESTORE: if (restore_valid) begin
               state <= last ? DONE : RESTORE;
               idx   <= last ? idx : idx + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign busy           = save_mode || rest_mode;
   assign cpu_stall      = busy;
   assign save_valid     = save_mode;
   assign restore_ready  = rest_mode;
   assign save_data      = rf_read1data;
   assign rf_read1regsel = save_mode ? idx : cpu_read1regsel;
   assign rf_writeregsel = rest_mode ? idx : cpu_writeregsel;
   assign rf_writedata   = rest_mode ? restore_data : cpu_writedata;
   assign rf_write       = rest_mode ? restore_valid : !rst && !busy && cpu_write;
   assign done           = !rst && state == DONE;
   assign err            = !rst && (state == IDLE ? save_start && restore_start : busy && (save_start || restore_start));
endmodule
